// File: rtl/vm_pkg.sv
// Shared definitions for the multi-product vending controller.
// Contents: coin code constants, coin_value() decoder, FSM state enum.
// Imported by vending_machine_multi.
package vm_pkg;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_1    = 2'b01;
  localparam logic [1:0] COIN_2    = 2'b10;
  localparam logic [1:0] COIN_5    = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CREDIT = 2'd1,
    VEND   = 2'd2,
    CHANGE = 2'd3
  } vm_state_t;

  // Unit value of a coin-acceptor code.
  function automatic logic [2:0] coin_value(input logic [1:0] code);
    case (code)
      COIN_1:  return 3'd1;
      COIN_2:  return 3'd2;
      COIN_5:  return 3'd5;
      default: return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/vm_change_counter.sv
// Loadable down-counter that emits one change pulse per cycle until it reaches zero.
// Latency: first pulse in the cycle after load; k pulses for load_val = k.
// Backpressure: none; a load overrides any count in progress.
// Ports: clk, rst_n (async active-low), load/load_val (start a refund),
//        change (registered pulse per unit), done (remaining count is zero).
module vm_change_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         change,
  output logic         done
);

  logic [W-1:0] cnt_q, cnt_d;
  logic         change_q, change_d;

  // The load cycle already produces the first pulse, so the stored count is
  // the number of pulses still owed after this one.
  always_comb begin
    cnt_d    = cnt_q;
    change_d = 1'b0;
    if (load) begin
      if (load_val != '0) begin
        change_d = 1'b1;
        cnt_d    = load_val - W'(1);
      end else begin
        cnt_d = '0;
      end
    end else if (cnt_q != '0) begin
      change_d = 1'b1;
      cnt_d    = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      change_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      change_q <= change_d;
    end
  end

  assign change = change_q;
  assign done   = (cnt_q == '0);

endmodule

// File: rtl/vending_machine_multi.sv
// Multi-product vending controller: 3-denomination credit, per-product prices, serial change.
// Latency: all outputs registered, one cycle after the causing input; refund of k units takes k cycles.
// Backpressure: coins/selections arriving while busy are bounced via coin_reject/sel_reject.
// Ports: coin/sel_valid/sel/cancel in; product_valid/product_id, change, coin_reject,
//        sel_reject, credit, busy out. Optional stock counters and restock port
//        are compiled in with the VM_STOCK_EN macro.
module vending_machine_multi
  import vm_pkg::*;
#(
  parameter int                           NUM_PROD   = 4,
  parameter int                           CREDIT_W   = 8,
  parameter int                           MAX_CREDIT = 50,
  parameter logic [NUM_PROD*CREDIT_W-1:0] PRICES     = {8'd15, 8'd10, 8'd7, 8'd3}
`ifdef VM_STOCK_EN
  ,
  parameter int                           STOCK_W    = 4,
  parameter int                           INIT_STOCK = 3
`endif
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [1:0]                  coin,
  input  logic                        sel_valid,
  input  logic [$clog2(NUM_PROD)-1:0] sel,
  input  logic                        cancel,
`ifdef VM_STOCK_EN
  input  logic                        restock,
`endif
  output logic                        product_valid,
  output logic [$clog2(NUM_PROD)-1:0] product_id,
  output logic                        change,
  output logic                        coin_reject,
  output logic                        sel_reject,
  output logic [CREDIT_W-1:0]         credit,
  output logic                        busy
);

  localparam int SEL_W = $clog2(NUM_PROD);

  vm_state_t           state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic                product_valid_q, product_valid_d;
  logic [SEL_W-1:0]    product_id_q, product_id_d;
  logic                coin_reject_q, coin_reject_d;
  logic                sel_reject_q, sel_reject_d;
  logic                busy_q, busy_d;

  logic                chg_load, chg_done;
  logic [CREDIT_W-1:0] price;
  logic                sel_in_range, stock_ok, coin_fits, coin_present;
  logic [CREDIT_W:0]   coin_sum;

  // Price mux; out-of-range indices read as 0 but are refused by sel_in_range.
  always_comb begin
    price = '0;
    for (int i = 0; i < NUM_PROD; i++) begin
      if (sel == SEL_W'(i)) price = PRICES[i*CREDIT_W +: CREDIT_W];
    end
  end

  assign sel_in_range = ({1'b0, sel} < (SEL_W+1)'(NUM_PROD));
  assign coin_present = (coin != COIN_NONE);
  // One extra bit so the ceiling compare cannot wrap.
  assign coin_sum     = {1'b0, credit_q} + (CREDIT_W+1)'(coin_value(coin));
  assign coin_fits    = (coin_sum <= (CREDIT_W+1)'(MAX_CREDIT));

`ifdef VM_STOCK_EN
  logic [STOCK_W-1:0] stock_q [NUM_PROD];
  logic [STOCK_W-1:0] stock_d [NUM_PROD];

  assign stock_ok = (stock_q[sel] != '0);

  // Restock wins over a same-cycle vend so the counter ends at INIT_STOCK.
  always_comb begin
    for (int i = 0; i < NUM_PROD; i++) begin
      stock_d[i] = stock_q[i];
      if (restock) begin
        stock_d[i] = STOCK_W'(INIT_STOCK);
      end else if (product_valid_d && (sel == SEL_W'(i))) begin
        stock_d[i] = stock_q[i] - STOCK_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_PROD; i++) stock_q[i] <= STOCK_W'(INIT_STOCK);
    end else begin
      for (int i = 0; i < NUM_PROD; i++) stock_q[i] <= stock_d[i];
    end
  end
`else
  assign stock_ok = 1'b1;
`endif

  always_comb begin
    state_d         = state_q;
    credit_d        = credit_q;
    product_valid_d = 1'b0;
    product_id_d    = product_id_q;
    coin_reject_d   = 1'b0;
    sel_reject_d    = 1'b0;
    chg_load        = 1'b0;

    case (state_q)
      IDLE, CREDIT: begin
        // Cancel only means something with credit held; in IDLE the coin still acts.
        if (cancel && (state_q == CREDIT)) begin
          state_d       = CHANGE;
          chg_load      = 1'b1;
          credit_d      = credit_q - CREDIT_W'(1);
          coin_reject_d = coin_present;
        end else if (sel_valid) begin
          coin_reject_d = coin_present;
          if (sel_in_range && stock_ok && (credit_q >= price)) begin
            state_d         = VEND;
            credit_d        = credit_q - price;
            product_valid_d = 1'b1;
            product_id_d    = sel;
          end else begin
            sel_reject_d = 1'b1;
          end
        end else if (coin_present) begin
          if (coin_fits) begin
            credit_d = coin_sum[CREDIT_W-1:0];
            state_d  = CREDIT;
          end else begin
            coin_reject_d = 1'b1;
          end
        end
      end

      VEND: begin
        coin_reject_d = coin_present;
        sel_reject_d  = sel_valid;
        if (credit_q != '0) begin
          state_d  = CHANGE;
          chg_load = 1'b1;
          credit_d = credit_q - CREDIT_W'(1);
        end else begin
          state_d = IDLE;
        end
      end

      CHANGE: begin
        coin_reject_d = coin_present;
        sel_reject_d  = sel_valid;
        // credit_q tracks the counter's remaining pulses one-for-one.
        if (chg_done) begin
          state_d = IDLE;
        end else begin
          credit_d = credit_q - CREDIT_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d == VEND) || (state_d == CHANGE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      credit_q        <= '0;
      product_valid_q <= 1'b0;
      product_id_q    <= '0;
      coin_reject_q   <= 1'b0;
      sel_reject_q    <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      credit_q        <= credit_d;
      product_valid_q <= product_valid_d;
      product_id_q    <= product_id_d;
      coin_reject_q   <= coin_reject_d;
      sel_reject_q    <= sel_reject_d;
      busy_q          <= busy_d;
    end
  end

  vm_change_counter #(.W(CREDIT_W)) u_change (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (chg_load),
    .load_val (credit_q),
    .change   (change),
    .done     (chg_done)
  );

  assign product_valid = product_valid_q;
  assign product_id    = product_id_q;
  assign coin_reject   = coin_reject_q;
  assign sel_reject    = sel_reject_q;
  assign credit        = credit_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_vending_machine_multi.sv
// Directed bench for vending_machine_multi (default parameters; prices 3/7/10/15 for products 0..3).
module tb_vending_machine_multi;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] coin = 2'b00;
  logic       sel_valid = 1'b0;
  logic [1:0] sel = 2'b00;
  logic       cancel = 1'b0;
`ifdef VM_STOCK_EN
  logic       restock = 1'b0;
`endif
  logic       product_valid;
  logic [1:0] product_id;
  logic       change;
  logic       coin_reject;
  logic       sel_reject;
  logic [7:0] credit;
  logic       busy;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  vending_machine_multi dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .coin          (coin),
    .sel_valid     (sel_valid),
    .sel           (sel),
    .cancel        (cancel),
`ifdef VM_STOCK_EN
    .restock       (restock),
`endif
    .product_valid (product_valid),
    .product_id    (product_id),
    .change        (change),
    .coin_reject   (coin_reject),
    .sel_reject    (sel_reject),
    .credit        (credit),
    .busy          (busy)
  );

  typedef struct {
    logic [1:0] coin;
    logic       sv;
    logic [1:0] sel;
    logic       cn;
    logic       pv;
    logic [1:0] pid;
    logic       ch;
    logic       crej;
    logic       srej;
    logic [7:0] cred;
    logic       busy;
  } vec_t;

  localparam int NV = 19;
  vec_t vecs [NV];

  function automatic vec_t mk(input int c, input int sv, input int s, input int cn,
                              input int pv, input int pid, input int ch, input int crej,
                              input int srej, input int cred, input int b);
    vec_t v;
    v.coin = 2'(c);   v.sv = 1'(sv);    v.sel = 2'(s);     v.cn = 1'(cn);
    v.pv = 1'(pv);    v.pid = 2'(pid);  v.ch = 1'(ch);     v.crej = 1'(crej);
    v.srej = 1'(srej); v.cred = 8'(cred); v.busy = 1'(b);
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Apply one cycle of inputs, then sample outputs 1 time unit after the edge.
  task automatic tick(input logic [1:0] c, input logic sv, input logic [1:0] s, input logic cn);
    coin = c; sel_valid = sv; sel = s; cancel = cn;
    @(posedge clk);
    #1;
    coin = 2'b00; sel_valid = 1'b0; cancel = 1'b0;
  endtask

  task automatic chk_all_idle(input string nm);
    chk({nm, ".pv"},     32'(product_valid), 32'd0);
    chk({nm, ".change"}, 32'(change),        32'd0);
    chk({nm, ".crej"},   32'(coin_reject),   32'd0);
    chk({nm, ".srej"},   32'(sel_reject),    32'd0);
    chk({nm, ".busy"},   32'(busy),          32'd0);
    chk({nm, ".credit"}, 32'(credit),        32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // coin codes: 1 -> 1 unit, 2 -> 2 units, 3 -> 5 units
    //             coin sv sel cn | pv pid ch crej srej cred busy
    vecs[0]  = mk(2, 0, 0, 0,  0, 0, 0, 0, 0,  2, 0);
    vecs[1]  = mk(1, 0, 0, 0,  0, 0, 0, 0, 0,  3, 0);
    vecs[2]  = mk(0, 1, 0, 0,  1, 0, 0, 0, 0,  0, 1);  // buy p0 (3)
    vecs[3]  = mk(0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0);  // no change owed
    vecs[4]  = mk(3, 0, 0, 0,  0, 0, 0, 0, 0,  5, 0);
    vecs[5]  = mk(3, 0, 0, 0,  0, 0, 0, 0, 0, 10, 0);
    vecs[6]  = mk(0, 1, 2, 0,  1, 2, 0, 0, 0,  0, 1);  // buy p2 (10)
    vecs[7]  = mk(0, 0, 0, 0,  0, 2, 0, 0, 0,  0, 0);  // product_id holds
    vecs[8]  = mk(3, 0, 0, 0,  0, 2, 0, 0, 0,  5, 0);
    vecs[9]  = mk(2, 1, 1, 0,  0, 2, 0, 1, 1,  5, 0);  // p1 (7) too dear, coin overridden
    vecs[10] = mk(2, 0, 0, 0,  0, 2, 0, 0, 0,  7, 0);
    vecs[11] = mk(0, 1, 3, 0,  0, 2, 0, 0, 1,  7, 0);  // p3 (15) too dear
    vecs[12] = mk(1, 1, 0, 0,  1, 0, 0, 1, 0,  4, 1);  // buy p0, coin overridden
    vecs[13] = mk(1, 1, 1, 1,  0, 0, 1, 1, 1,  3, 1);  // in VEND: bounce, cancel ignored
    vecs[14] = mk(0, 0, 0, 1,  0, 0, 1, 0, 0,  2, 1);  // cancel ignored in CHANGE
    vecs[15] = mk(0, 0, 0, 0,  0, 0, 1, 0, 0,  1, 1);
    vecs[16] = mk(0, 0, 0, 0,  0, 0, 1, 0, 0,  0, 1);  // 4th change pulse
    vecs[17] = mk(0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0);  // back to IDLE
    vecs[18] = mk(0, 0, 0, 1,  0, 0, 0, 0, 0,  0, 0);  // cancel in IDLE: no effect

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk_all_idle("reset");
    chk("reset.pid", 32'(product_id), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      tick(vecs[i].coin, vecs[i].sv, vecs[i].sel, vecs[i].cn);
      chk($sformatf("v%0d.pv", i),     32'(product_valid), 32'(vecs[i].pv));
      chk($sformatf("v%0d.pid", i),    32'(product_id),    32'(vecs[i].pid));
      chk($sformatf("v%0d.change", i), 32'(change),        32'(vecs[i].ch));
      chk($sformatf("v%0d.crej", i),   32'(coin_reject),   32'(vecs[i].crej));
      chk($sformatf("v%0d.srej", i),   32'(sel_reject),    32'(vecs[i].srej));
      chk($sformatf("v%0d.credit", i), 32'(credit),        32'(vecs[i].cred));
      chk($sformatf("v%0d.busy", i),   32'(busy),          32'(vecs[i].busy));
    end

    // Fill to the 50-unit ceiling, overflow coin, then a full refund.
    for (int k = 1; k <= 10; k++) begin
      tick(2'b11, 1'b0, 2'b00, 1'b0);
      chk($sformatf("fill%0d.credit", k), 32'(credit), 32'(5 * k));
      chk($sformatf("fill%0d.crej", k),   32'(coin_reject), 32'd0);
    end
    tick(2'b01, 1'b0, 2'b00, 1'b0);
    chk("over.crej",   32'(coin_reject), 32'd1);
    chk("over.credit", 32'(credit),      32'd50);
    tick(2'b00, 1'b0, 2'b00, 1'b1);
    chk("refund0.change", 32'(change), 32'd1);
    chk("refund0.credit", 32'(credit), 32'd49);
    for (int k = 1; k < 50; k++) begin
      tick(2'b00, 1'b0, 2'b00, 1'b0);
      chk($sformatf("refund%0d.change", k), 32'(change), 32'd1);
      chk($sformatf("refund%0d.credit", k), 32'(credit), 32'(49 - k));
      chk($sformatf("refund%0d.busy", k),   32'(busy),   32'd1);
    end
    tick(2'b00, 1'b0, 2'b00, 1'b0);
    chk_all_idle("refund_end");

    // Credit 12, buy p2 (10), reset during the 2-unit change.
    tick(2'b11, 1'b0, 2'b00, 1'b0);
    tick(2'b11, 1'b0, 2'b00, 1'b0);
    tick(2'b10, 1'b0, 2'b00, 1'b0);
    chk("r12.credit", 32'(credit), 32'd12);
    tick(2'b00, 1'b1, 2'b10, 1'b0);
    chk("r12.pv",     32'(product_valid), 32'd1);
    chk("r12.pid",    32'(product_id),    32'd2);
    chk("r12.credit_after_vend", 32'(credit), 32'd2);
    tick(2'b00, 1'b0, 2'b00, 1'b0);
    chk("r12.change1", 32'(change), 32'd1);
    chk("r12.credit1", 32'(credit), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_idle("async_rst");
    chk("async_rst.pid", 32'(product_id), 32'd0);
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("in_rst%0d.change", k), 32'(change), 32'd0);
    end
    rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick(2'b00, 1'b0, 2'b00, 1'b0);
      chk_all_idle($sformatf("post_rst%0d", k));
    end

`ifdef VM_STOCK_EN
    restock = 1'b1;
    tick(2'b00, 1'b0, 2'b00, 1'b0);
    restock = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick(2'b10, 1'b0, 2'b00, 1'b0);
      tick(2'b01, 1'b0, 2'b00, 1'b0);
      tick(2'b00, 1'b1, 2'b00, 1'b0);
      chk($sformatf("stock%0d.pv", k), 32'(product_valid), 32'd1);
      tick(2'b00, 1'b0, 2'b00, 1'b0);
    end
    tick(2'b10, 1'b0, 2'b00, 1'b0);
    tick(2'b01, 1'b0, 2'b00, 1'b0);
    tick(2'b00, 1'b1, 2'b00, 1'b0);
    chk("empty.pv",     32'(product_valid), 32'd0);
    chk("empty.srej",   32'(sel_reject),    32'd1);
    chk("empty.credit", 32'(credit),        32'd3);
    restock = 1'b1;
    tick(2'b00, 1'b0, 2'b00, 1'b0);
    restock = 1'b0;
    chk("restock.credit", 32'(credit), 32'd3);
    tick(2'b00, 1'b1, 2'b00, 1'b0);
    chk("restocked.pv",   32'(product_valid), 32'd1);
    chk("restocked.srej", 32'(sel_reject),    32'd0);
    tick(2'b00, 1'b0, 2'b00, 1'b0);
    chk_all_idle("stock_end");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
